sprite_blit_engine: RTL and testbench



---
 rtl/sprite_blit_pkg.sv | 49 ++++
 rtl/sprite_blit_engine_if.sv | 28 ++
 rtl/sprite_geometry_lut.sv | 25 ++
 rtl/sprite_blit_engine.sv | 184 ++++++++++++++++++
 tb/tb_sprite_blit_engine.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_blit_pkg.sv
// Shared types and constants for the sprite blitter: FSM states, the geometry
// record, and the per-ROMId geometry table that maps each sprite to its ROM region.
package sprite_blit_pkg;

  localparam int SCREEN_W_DEFAULT = 240;
  localparam int SCREEN_H_DEFAULT = 320;

  localparam logic [15:0] COLOUR_KEY = 16'hF81F;

  localparam logic [3:0] ROMID_FLOOR      = 4'd5;
  localparam logic [3:0] ROMID_TITLE      = 4'd9;
  localparam logic [3:0] ROMID_GAMEOVER   = 4'd10;
  localparam logic [3:0] ROMID_BACKGROUND = 4'd11;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FETCH,
    WAIT,
    EMIT,
    NEXT,
    DONE
  } blit_state_e;

  typedef struct packed {
    logic [7:0]  w;
    logic [8:0]  h;
    logic [16:0] base;
  } geom_t;

  // Sprites are packed back to back in the ROM; w=0 marks an unused id.
  function automatic geom_t geometry_entry(input logic [3:0] id);
    geom_t g;
    g = '0;
    case (id)
      4'd0:             g = '{w: 8'd2,   h: 9'd2,   base: 17'd0};
      4'd1:             g = '{w: 8'd16,  h: 9'd16,  base: 17'd4};
      4'd2:             g = '{w: 8'd8,   h: 9'd8,   base: 17'd260};
      ROMID_FLOOR:      g = '{w: 8'd32,  h: 9'd32,  base: 17'd324};
      4'd6:             g = '{w: 8'd3,   h: 9'd5,   base: 17'd1348};
      ROMID_TITLE:      g = '{w: 8'd200, h: 9'd60,  base: 17'd1363};
      ROMID_GAMEOVER:   g = '{w: 8'd160, h: 9'd40,  base: 17'd13363};
      ROMID_BACKGROUND: g = '{w: 8'd240, h: 9'd320, base: 17'd19763};
      default:          g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sprite_blit_engine_if.sv
// Draw handshake, sprite ROM port and LT24 pixel-write port of the blitter.
// The engine uses the slave modport; the surrounding system drives the master side.
interface sprite_blit_engine_if #(
  parameter int ROM_ADDR_W = 17
);
  logic                  draw;
  logic [7:0]            xOrigin;
  logic [8:0]            yOrigin;
  logic [3:0]            ROMId;
  logic                  ready;
  logic [ROM_ADDR_W-1:0] romAddr;
  logic [15:0]           romData;
  logic                  pixelWrite;
  logic [7:0]            pixelX;
  logic [8:0]            pixelY;
  logic [15:0]           pixelData;
  logic                  pixelReady;

  modport slave (
    input  draw, xOrigin, yOrigin, ROMId, romData, pixelReady,
    output ready, romAddr, pixelWrite, pixelX, pixelY, pixelData
  );

  modport master (
    output draw, xOrigin, yOrigin, ROMId, romData, pixelReady,
    input  ready, romAddr, pixelWrite, pixelX, pixelY, pixelData
  );
endinterface

// File: rtl/sprite_geometry_lut.sv
// Registered ROMId -> {W, H, base} lookup; loads on the draw trigger so the
// geometry is valid during LOOKUP and holds for the rest of the blit.
module sprite_geometry_lut
  import sprite_blit_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load_i,
  input  logic [3:0] rom_id_i,
  output geom_t      geom_o
);

  geom_t geom_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      geom_q <= '0;
    end else if (load_i) begin
      geom_q <= geometry_entry(rom_id_i);
    end
  end

  assign geom_o = geom_q;

endmodule

// File: rtl/sprite_blit_engine.sv
// Sprite blitter: walks a sprite row by row from ROM and issues on-screen pixels
// as handshaked writes. Optional `SPRITE_TRANSPARENCY_EN skips colour-key pixels.
module sprite_blit_engine
  import sprite_blit_pkg::*;
#(
  parameter int SCREEN_W    = SCREEN_W_DEFAULT,
  parameter int SCREEN_H    = SCREEN_H_DEFAULT,
  parameter int ROM_ADDR_W  = 17,
  parameter int ROM_LATENCY = 1
) (
  input logic                  clock,
  input logic                  reset_n,
  sprite_blit_engine_if.slave  bus
);

  localparam logic [1:0] LAT = 2'(ROM_LATENCY);

  blit_state_e           state_q, state_d;
  logic                  draw_prev_q;
  logic [7:0]            x_org_q, x_org_d;
  logic [8:0]            y_org_q, y_org_d;
  logic [7:0]            col_q, col_d;
  logic [8:0]            row_q, row_d;
  logic [ROM_ADDR_W-1:0] row_base_q, row_base_d;
  logic [1:0]            wait_cnt_q, wait_cnt_d;
  logic [ROM_ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]            pix_x_q, pix_x_d;
  logic [8:0]            pix_y_q, pix_y_d;
  logic [15:0]           pix_data_q, pix_data_d;

  geom_t                 geom;
  logic                  trigger;
  logic [ROM_ADDR_W-1:0] base_ext, w_ext;
  logic [8:0]            px_x;
  logic [9:0]            px_y;
  logic                  x_off, y_off, transparent, visible;
  logic                  last_col, last_row;

  assign trigger = (state_q == IDLE) && bus.draw && !draw_prev_q;

  sprite_geometry_lut u_geom (
    .clock    (clock),
    .reset_n  (reset_n),
    .load_i   (trigger),
    .rom_id_i (bus.ROMId),
    .geom_o   (geom)
  );

  assign base_ext = ROM_ADDR_W'(geom.base);
  assign w_ext    = ROM_ADDR_W'(geom.w);

  // 9-bit two's complement x; bit 8 set means the column lies left of the screen.
  assign px_x  = {1'b0, x_org_q} - {1'b0, geom.w} + 9'd1 + {1'b0, col_q};
  assign px_y  = {1'b0, y_org_q} + {1'b0, row_q};
  assign x_off = px_x[8] || (px_x >= 9'(SCREEN_W));
  assign y_off = px_y >= 10'(SCREEN_H);

`ifdef SPRITE_TRANSPARENCY_EN
  assign transparent = (bus.romData == COLOUR_KEY);
`else
  assign transparent = 1'b0;
`endif

  assign visible  = !x_off && !y_off && !transparent;
  assign last_col = (col_q == geom.w - 8'd1);
  assign last_row = (row_q == geom.h - 9'd1);

  always_comb begin
    state_d    = state_q;
    x_org_d    = x_org_q;
    y_org_d    = y_org_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    wait_cnt_d = wait_cnt_q;
    rom_addr_d = rom_addr_q;
    pix_x_d    = pix_x_q;
    pix_y_d    = pix_y_q;
    pix_data_d = pix_data_q;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          x_org_d = bus.xOrigin;
          y_org_d = bus.yOrigin;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (geom.w == 8'd0) begin
          state_d = DONE;
        end else begin
          col_d      = '0;
          row_d      = '0;
          row_base_d = '0;
          rom_addr_d = base_ext;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        wait_cnt_d = 2'd1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (wait_cnt_q >= LAT) begin
          if (visible) begin
            pix_x_d    = px_x[7:0];
            pix_y_d    = px_y[8:0];
            pix_data_d = bus.romData;
            state_d    = EMIT;
          end else begin
            state_d    = NEXT;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      EMIT: begin
        if (bus.pixelReady) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (last_col && last_row) begin
          state_d = DONE;
        end else begin
          if (last_col) begin
            col_d      = '0;
            row_d      = row_q + 9'd1;
            row_base_d = row_base_q + w_ext;
          end else begin
            col_d      = col_q + 8'd1;
          end
          rom_addr_d = base_ext + row_base_d + ROM_ADDR_W'(col_d);
          state_d    = FETCH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      draw_prev_q <= 1'b0;
      x_org_q     <= '0;
      y_org_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      row_base_q  <= '0;
      wait_cnt_q  <= '0;
      rom_addr_q  <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      draw_prev_q <= bus.draw;
      x_org_q     <= x_org_d;
      y_org_q     <= y_org_d;
      col_q       <= col_d;
      row_q       <= row_d;
      row_base_q  <= row_base_d;
      wait_cnt_q  <= wait_cnt_d;
      rom_addr_q  <= rom_addr_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_data_q  <= pix_data_d;
    end
  end

  assign bus.ready      = (state_q == IDLE);
  assign bus.pixelWrite = (state_q == EMIT);
  assign bus.romAddr    = rom_addr_q;
  assign bus.pixelX     = pix_x_q;
  assign bus.pixelY     = pix_y_q;
  assign bus.pixelData  = pix_data_q;

endmodule

// File: tb/tb_sprite_blit_engine.sv
// Randomized self-checking bench for sprite_blit_engine against a loop-based
// reference model of the sprite walk, clipping and transparency rules.
module tb_sprite_blit_engine;

  localparam int AW      = 17;
  localparam int ROM_LAT = 1;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #10 clock = ~clock;

  sprite_blit_engine_if #(.ROM_ADDR_W(AW)) bus ();

  sprite_blit_engine #(
    .SCREEN_W    (240),
    .SCREEN_H    (320),
    .ROM_ADDR_W  (AW),
    .ROM_LATENCY (ROM_LAT)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Sprite ROM model with configurable read latency
  logic [15:0] rom_mem [0:(1<<AW)-1];
  logic [15:0] rom_p1, rom_p2;
  always @(posedge clock) begin
    rom_p1 <= rom_mem[bus.romAddr];
    rom_p2 <= rom_p1;
  end
  assign bus.romData = (ROM_LAT == 2) ? rom_p2 : rom_p1;

  // Monitor: accepted writes and every change of romAddr
  int wx_q[$], wy_q[$], wd_q[$], addr_q[$];
  logic [AW-1:0] last_addr = '0;
  always @(posedge clock) begin
    if (bus.pixelWrite && bus.pixelReady) begin
      wx_q.push_back(int'(bus.pixelX));
      wy_q.push_back(int'(bus.pixelY));
      wd_q.push_back(int'(bus.pixelData));
    end
    if (bus.romAddr != last_addr) begin
      addr_q.push_back(int'(bus.romAddr));
      last_addr <= bus.romAddr;
    end
  end

  int ex_x[$], ex_y[$], ex_d[$];

  task automatic tb_geom(input int id, output int w, output int h, output int b);
    w = 0; h = 0; b = 0;
    case (id)
      0:  begin w = 2;   h = 2;   b = 0;     end
      1:  begin w = 16;  h = 16;  b = 4;     end
      2:  begin w = 8;   h = 8;   b = 260;   end
      5:  begin w = 32;  h = 32;  b = 324;   end
      6:  begin w = 3;   h = 5;   b = 1348;  end
      9:  begin w = 200; h = 60;  b = 1363;  end
      10: begin w = 160; h = 40;  b = 13363; end
      11: begin w = 240; h = 320; b = 19763; end
      default: begin w = 0; h = 0; b = 0; end
    endcase
  endtask

  // Expected write list: every sprite pixel in row-major order, minus clipped/keyed ones
  task automatic build_expected(input int id, input int xo, input int yo);
    int w, h, b, x, y, d;
    ex_x.delete(); ex_y.delete(); ex_d.delete();
    tb_geom(id, w, h, b);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        x = xo - w + 1 + c;
        y = yo + r;
        d = int'(rom_mem[b + r * w + c]);
        if (x < 0 || x >= 240 || y >= 320) continue;
`ifdef SPRITE_TRANSPARENCY_EN
        if (d == 32'hF81F) continue;
`endif
        ex_x.push_back(x); ex_y.push_back(y); ex_d.push_back(d);
      end
    end
  endtask

  function automatic int first_mismatch(input int start);
    for (int i = 0; i < ex_x.size(); i++) begin
      if (start + i >= wx_q.size()) return i;
      if (wx_q[start+i] != ex_x[i] || wy_q[start+i] != ex_y[i] || wd_q[start+i] != ex_d[i])
        return i;
    end
    return -1;
  endfunction

  // Rising edge of draw, then wait for ready to drop and come back
  task automatic run_blit(input int id, input int xo, input int yo, input bit rnd, output bit done);
    bit seen_busy;
    done = 1'b0;
    seen_busy = 1'b0;
    @(negedge clock);
    bus.draw = 1'b0;
    bus.ROMId = 4'(id);
    bus.xOrigin = 8'(xo);
    bus.yOrigin = 9'(yo);
    bus.pixelReady = 1'b1;
    @(negedge clock);
    bus.draw = 1'b1;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clock);
      if (!seen_busy && !bus.ready) seen_busy = 1'b1;
      else if (seen_busy && bus.ready) begin
        done = 1'b1;
        break;
      end
      if (rnd) begin
        bus.pixelReady = ($urandom_range(0, 3) != 0);
        bus.draw       = 1'($urandom_range(0, 1));
        bus.xOrigin    = 8'($urandom);
        bus.yOrigin    = 9'($urandom);
        bus.ROMId      = 4'($urandom);
      end
    end
    if (rnd) bus.draw = 1'b0;
    bus.pixelReady = 1'b1;
    $display("blit id=%0d x=%0d y=%0d done=%0d total_writes=%0d", id, xo, yo, done, wx_q.size());
  endtask

  task automatic test_reset();
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", bus.ready); end
    checks++; if (bus.pixelWrite !== 1'b0) begin errors++; $display("FAIL reset_pixelWrite got %0b want 0", bus.pixelWrite); end
    checks++; if (bus.romAddr !== '0) begin errors++; $display("FAIL reset_romAddr got %0h want 0", bus.romAddr); end
    checks++; if (bus.pixelX !== 8'd0) begin errors++; $display("FAIL reset_pixelX got %0d want 0", bus.pixelX); end
    checks++; if (bus.pixelY !== 9'd0) begin errors++; $display("FAIL reset_pixelY got %0d want 0", bus.pixelY); end
    checks++; if (bus.pixelData !== 16'd0) begin errors++; $display("FAIL reset_pixelData got %0h want 0", bus.pixelData); end
  endtask

  task automatic test_floor();
    int s, a, n, na, bad, m;
    bit done;
    s = wx_q.size(); a = addr_q.size();
    build_expected(5, 31, 100);
    run_blit(5, 31, 100, 1'b0, done);
    n = wx_q.size() - s;
    checks++; if (!done) begin errors++; $display("FAIL floor_ready_return got %0b want 1", done); end
    checks++; if (n != 1024) begin errors++; $display("FAIL floor_count got %0d want 1024", n); end
    if (n > 0) begin
      checks++;
      if (wx_q[s] != 0 || wy_q[s] != 100) begin
        errors++; $display("FAIL floor_first got (%0d,%0d) want (0,100)", wx_q[s], wy_q[s]);
      end
      checks++;
      if (wx_q[s+n-1] != 31 || wy_q[s+n-1] != 131) begin
        errors++; $display("FAIL floor_last got (%0d,%0d) want (31,131)", wx_q[s+n-1], wy_q[s+n-1]);
      end
    end
    m = first_mismatch(s);
    checks++; if (m != -1) begin errors++; $display("FAIL floor_model first bad index %0d want none", m); end
    na = addr_q.size() - a;
    checks++; if (na != 1024) begin errors++; $display("FAIL floor_addr_count got %0d want 1024", na); end
    bad = -1;
    for (int i = 0; i < na && i < 1024; i++) begin
      if (addr_q[a+i] != 324 + i) begin bad = i; break; end
    end
    checks++;
    if (bad != -1) begin
      errors++; $display("FAIL floor_addr_seq index %0d got %0d want %0d", bad, addr_q[a+bad], 324 + bad);
    end
  endtask

  task automatic test_clip();
    int s, n, m, xmin, xmax, ymin, ymax;
    bit done;
    s = wx_q.size();
    build_expected(5, 15, 300);
    run_blit(5, 15, 300, 1'b0, done);
    n = wx_q.size() - s;
    checks++; if (!done) begin errors++; $display("FAIL clip_ready_return got %0b want 1", done); end
    checks++; if (n != 320) begin errors++; $display("FAIL clip_count got %0d want 320", n); end
    xmin = 999; xmax = -1; ymin = 999; ymax = -1;
    for (int i = s; i < wx_q.size(); i++) begin
      if (wx_q[i] < xmin) xmin = wx_q[i];
      if (wx_q[i] > xmax) xmax = wx_q[i];
      if (wy_q[i] < ymin) ymin = wy_q[i];
      if (wy_q[i] > ymax) ymax = wy_q[i];
    end
    checks++;
    if (xmin != 0 || xmax != 15 || ymin != 300 || ymax != 319) begin
      errors++; $display("FAIL clip_range got x %0d..%0d y %0d..%0d want x 0..15 y 300..319", xmin, xmax, ymin, ymax);
    end
    m = first_mismatch(s);
    checks++; if (m != -1) begin errors++; $display("FAIL clip_model first bad index %0d want none", m); end
  endtask

  task automatic test_backpressure();
    int s, n, m, seen;
    bit seen_busy, done, stable;
    logic [7:0] hx; logic [8:0] hy; logic [15:0] hd;
    s = wx_q.size(); seen = 0; seen_busy = 1'b0; done = 1'b0; stable = 1'b1;
    hx = '0; hy = '0; hd = '0;
    build_expected(1, 100, 50);
    @(negedge clock);
    bus.draw = 1'b0; bus.ROMId = 4'd1; bus.xOrigin = 8'd100; bus.yOrigin = 9'd50; bus.pixelReady = 1'b0;
    @(negedge clock);
    bus.draw = 1'b1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clock);
      if (!seen_busy && !bus.ready) seen_busy = 1'b1;
      else if (seen_busy && bus.ready) begin done = 1'b1; break; end
      if (bus.pixelReady) bus.pixelReady = 1'b0;
      else if (bus.pixelWrite) begin
        seen++;
        if (seen == 3) begin
          hx = bus.pixelX; hy = bus.pixelY; hd = bus.pixelData;
          for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (bus.pixelWrite !== 1'b1 || bus.pixelX !== hx || bus.pixelY !== hy || bus.pixelData !== hd)
              stable = 1'b0;
          end
        end
        bus.pixelReady = 1'b1;
      end
    end
    bus.pixelReady = 1'b1;
    $display("blit id=1 x=100 y=50 backpressured done=%0d total_writes=%0d", done, wx_q.size());
    n = wx_q.size() - s;
    checks++; if (!done) begin errors++; $display("FAIL bp_ready_return got %0b want 1", done); end
    checks++; if (!stable) begin errors++; $display("FAIL bp_hold got %0b want 1 (x=%0d y=%0d d=%0h)", stable, hx, hy, hd); end
    checks++; if (n != ex_x.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", n, ex_x.size()); end
    m = first_mismatch(s);
    checks++; if (m != -1) begin errors++; $display("FAIL bp_model first bad index %0d want none", m); end
  endtask

  task automatic test_retrigger();
    int s, n, m;
    bit done, stayed;
    s = wx_q.size();
    run_blit(2, 50, 60, 1'b0, done);
    checks++; if (wx_q.size() - s != 64) begin errors++; $display("FAIL retrig_first_count got %0d want 64", wx_q.size() - s); end
    s = wx_q.size(); stayed = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (!bus.ready) stayed = 1'b0;
    end
    checks++; if (!stayed) begin errors++; $display("FAIL retrig_ready_held got %0b want 1", stayed); end
    checks++; if (wx_q.size() != s) begin errors++; $display("FAIL retrig_no_writes got %0d want 0", wx_q.size() - s); end
    build_expected(2, 50, 60);
    run_blit(2, 50, 60, 1'b0, done);
    n = wx_q.size() - s;
    checks++; if (!done) begin errors++; $display("FAIL retrig_second_done got %0b want 1", done); end
    checks++; if (n != 64) begin errors++; $display("FAIL retrig_second_count got %0d want 64", n); end
    m = first_mismatch(s);
    checks++; if (m != -1) begin errors++; $display("FAIL retrig_model first bad index %0d want none", m); end
    bus.draw = 1'b0;
  endtask

  task automatic test_transparency();
    int s, n, bad;
    int exp_d[$];
    bit done;
`ifdef SPRITE_TRANSPARENCY_EN
    exp_d = '{32'h1234, 32'hABCD};
`else
    exp_d = '{32'hF81F, 32'h1234, 32'hF81F, 32'hABCD};
`endif
    s = wx_q.size();
    run_blit(0, 100, 100, 1'b0, done);
    n = wx_q.size() - s;
    checks++; if (n != exp_d.size()) begin errors++; $display("FAIL transp_count got %0d want %0d", n, exp_d.size()); end
    bad = -1;
    for (int i = 0; i < n && i < exp_d.size(); i++) begin
      if (wd_q[s+i] != exp_d[i]) begin bad = i; break; end
    end
    checks++;
    if (bad != -1) begin errors++; $display("FAIL transp_data index %0d got %0h want %0h", bad, wd_q[s+bad], exp_d[bad]); end
  endtask

  task automatic test_reset_midblit();
    int s;
    bit hit, stayed;
    hit = 1'b0; stayed = 1'b1;
    @(negedge clock);
    bus.draw = 1'b0; bus.ROMId = 4'd5; bus.xOrigin = 8'd31; bus.yOrigin = 9'd100; bus.pixelReady = 1'b0;
    @(negedge clock);
    bus.draw = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (bus.pixelWrite) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL midreset_reach_emit got %0b want 1", hit); end
    reset_n = 1'b0;
    bus.draw = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    checks++; if (bus.pixelWrite !== 1'b0) begin errors++; $display("FAIL midreset_pixelWrite got %0b want 0", bus.pixelWrite); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %0b want 1", bus.ready); end
    s = wx_q.size();
    bus.pixelReady = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!bus.ready) stayed = 1'b0;
    end
    checks++; if (wx_q.size() != s || !stayed) begin
      errors++; $display("FAIL midreset_quiet got %0d writes ready_held=%0b want 0 writes ready_held=1", wx_q.size() - s, stayed);
    end
    $display("blit id=5 aborted by reset, total_writes=%0d", wx_q.size());
  endtask

  task automatic test_random();
    int ids[7] = '{0, 1, 2, 3, 5, 6, 7};
    int id, xo, yo, s, n, m;
    bit done;
    for (int it = 0; it < 8; it++) begin
      id = ids[$urandom_range(0, 6)];
      xo = $urandom_range(0, 239);
      yo = $urandom_range(0, 400);
      s = wx_q.size();
      build_expected(id, xo, yo);
      run_blit(id, xo, yo, 1'b1, done);
      n = wx_q.size() - s;
      checks++; if (!done) begin errors++; $display("FAIL rand%0d_done got %0b want 1", it, done); end
      checks++; if (n != ex_x.size()) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", it, n, ex_x.size()); end
      m = first_mismatch(s);
      checks++; if (m != -1) begin errors++; $display("FAIL rand%0d_model first bad index %0d want none", it, m); end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = 16'($urandom);
    rom_mem[0] = 16'hF81F;
    rom_mem[1] = 16'h1234;
    rom_mem[2] = 16'hF81F;
    rom_mem[3] = 16'hABCD;
    bus.draw = 1'b0;
    bus.xOrigin = '0;
    bus.yOrigin = '0;
    bus.ROMId = '0;
    bus.pixelReady = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    test_reset();
    test_floor();
    test_clip();
    test_backpressure();
    test_retrigger();
    test_transparency();
    test_random();
    test_reset_midblit();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
